// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a small FIFO. It issues them one
// at a time to a registered 8-bit ALU. Each result/status is returned with the
// command tag on a valid/ready response port. Illegal opcodes and ALU timeouts
// come back as error responses.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned WAIT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [4:0]                 cmd_op,
  input  logic [7:0]                 cmd_in1,
  input  logic [7:0]                 cmd_in2,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic                       alu_enable,
  output logic [7:0]                 alu_in1,
  output logic [7:0]                 alu_in2,
  output logic [4:0]                 alu_op,
  input  logic [7:0]                 alu_out,
  input  logic [4:0]                 alu_status,
  input  logic                       alu_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_data,
  output logic [4:0]                 rsp_status,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_error,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam int unsigned ENTRY_W = 5 + 8 + 8 + TAG_W;
  localparam int unsigned WCW     = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [ENTRY_W-1:0]  mem_d [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [WCW-1:0]      wait_cnt_q, wait_cnt_d;
  logic [WCW-1:0]      wait_cnt_nxt;
  logic [7:0]          rsp_data_q, rsp_data_d;
  logic [4:0]          rsp_status_q, rsp_status_d;
  logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
  logic                rsp_error_q, rsp_error_d;

  logic                full, empty, push, pop;
  logic [ENTRY_W-1:0]  head;
  logic [4:0]          head_op;
  logic [7:0]          head_in1, head_in2;
  logic [TAG_W-1:0]    head_tag;
  logic                head_legal;

  // FIFO status, head decode and push qualification
  always_comb begin
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    push       = cmd_valid && !full;
    head       = mem_q[rd_ptr_q];
    head_op    = head[ENTRY_W-1 -: 5];
    head_in1   = head[ENTRY_W-6 -: 8];
    head_in2   = head[ENTRY_W-14 -: 8];
    head_tag   = head[TAG_W-1:0];
    head_legal = (head_op >= 5'd1) && (head_op <= 5'd13);
  end

  // FIFO storage and pointer/occupancy update
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {cmd_op, cmd_in1, cmd_in2, cmd_tag};
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next state: issue, wait for ALU or timeout, hold response
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    wait_cnt_nxt = wait_cnt_q + WCW'(1);
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_error_d  = rsp_error_q;
    pop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A push on this edge is enough to reach ISSUE in the next cycle
        if (!empty || push) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (head_legal) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else begin
          pop          = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = '0;
          rsp_error_d  = 1'b1;
          rsp_tag_d    = head_tag;
          state_d      = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (alu_ready) begin
          pop          = 1'b1;
          rsp_data_d   = alu_out;
          rsp_status_d = alu_status;
          rsp_error_d  = 1'b0;
          rsp_tag_d    = head_tag;
          state_d      = ST_RESP;
        end else if (wait_cnt_nxt == WCW'(WAIT_MAX)) begin
          pop          = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = '0;
          rsp_error_d  = 1'b1;
          rsp_tag_d    = head_tag;
          state_d      = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_nxt;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = (!empty || push) ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All sequencer and FIFO state, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_cnt_q   <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rsp_tag_q    <= '0;
      rsp_error_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_cnt_q   <= wait_cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_error_q  <= rsp_error_d;
      mem_q        <= mem_d;
    end
  end

  // ALU drive decoded from registered state and FIFO head; zero when idle
  always_comb begin
    alu_enable = ((state_q == ST_ISSUE) && head_legal) || (state_q == ST_WAIT);
    alu_op     = alu_enable ? head_op  : '0;
    alu_in1    = alu_enable ? head_in1 : '0;
    alu_in2    = alu_enable ? head_in2 : '0;
    cmd_ready  = !full;
    rsp_valid  = (state_q == ST_RESP);
    rsp_data   = rsp_data_q;
    rsp_status = rsp_status_q;
    rsp_tag    = rsp_tag_q;
    rsp_error  = rsp_error_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: table-driven single commands plus
// directed back-to-back, backpressure, timeout and reset sequences.
module tb_alu_cmd_sequencer;

  localparam int unsigned WAIT_MAX = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, cmd_ready;
  logic [4:0] cmd_op;
  logic [7:0] cmd_in1, cmd_in2;
  logic [3:0] cmd_tag;
  logic       alu_enable;
  logic [7:0] alu_in1, alu_in2;
  logic [4:0] alu_op;
  logic [7:0] alu_out;
  logic [4:0] alu_status;
  logic       alu_ready;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [4:0] rsp_status;
  logic [3:0] rsp_tag;
  logic       rsp_error;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  logic alu_gate = 1'b1;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .DEPTH(4),
    .TAG_W(4),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_tag(cmd_tag),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_op(alu_op), .alu_out(alu_out), .alu_status(alu_status),
    .alu_ready(alu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_tag(rsp_tag), .rsp_error(rsp_error),
    .fifo_count(fifo_count)
  );

  // Registered ALU model: 1=ADD, 2=SUB, 11=CMPEQ, other legal ops XOR
  logic [8:0] m_sum;
  logic [7:0] m_dif;
  assign m_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
  assign m_dif = alu_in1 - alu_in2;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_ready  <= 1'b0;
      alu_out    <= '0;
      alu_status <= '0;
    end else begin
      alu_ready <= alu_enable && alu_gate;
      case (alu_op)
        5'd1:  begin alu_out <= m_sum[7:0]; alu_status <= {m_sum[8], m_sum[7], 3'b000}; end
        5'd2:  begin alu_out <= m_dif; alu_status <= {1'b0, m_dif[7], 3'b000}; end
        5'd11: begin
          alu_out    <= '0;
          alu_status <= {2'b00, alu_in1 == alu_in2, alu_in1 < alu_in2, alu_in1 > alu_in2};
        end
        default: begin alu_out <= alu_in1 ^ alu_in2; alu_status <= '0; end
      endcase
    end
  end

  always @(negedge clk) if (alu_enable) en_cnt <= en_cnt + 1;

  typedef struct {
    logic [4:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [3:0] tag;
    logic [7:0] data;
    logic [4:0] status;
    logic       err;
    int         lat;
    int         en;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int en0;
    @(negedge clk);
    en0       = en_cnt;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_in1   = v.in1;
    cmd_in2   = v.in2;
    cmd_tag   = v.tag;
    rsp_ready = 1'b1;
    chk("vec_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    chk("vec_issue_en", alu_enable, !v.err);
    if (!v.err) begin
      chk("vec_issue_op", alu_op, v.op);
      chk("vec_issue_in1", alu_in1, v.in1);
    end
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_rsp_valid", rsp_valid, 1);
    chk("vec_latency", lat, v.lat);
    chk("vec_data", rsp_data, v.data);
    chk("vec_status", rsp_status, v.status);
    chk("vec_tag", rsp_tag, v.tag);
    chk("vec_error", rsp_error, v.err);
    @(negedge clk);
    chk("vec_rsp_drop", rsp_valid, 0);
    chk("vec_en_cycles", en_cnt - en0, v.en);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, nresp, t1, t2, acc, exp_tag, lat, en0, viol;
    logic [7:0] d1, d2;
    logic [4:0] s1, s2;
    logic [3:0] g1, g2;

    vecs[0] = '{5'd1,  8'd200, 8'd100, 4'd3,  8'h2C, 5'b10000, 1'b0, 3, 2};
    vecs[1] = '{5'd2,  8'd5,   8'd7,   4'd4,  8'hFE, 5'b01000, 1'b0, 3, 2};
    vecs[2] = '{5'd11, 8'd9,   8'd9,   4'd5,  8'h00, 5'b00100, 1'b0, 3, 2};
    vecs[3] = '{5'd31, 8'd1,   8'd2,   4'd7,  8'h00, 5'b00000, 1'b1, 2, 0};
    vecs[4] = '{5'd0,  8'd3,   8'd4,   4'd8,  8'h00, 5'b00000, 1'b1, 2, 0};
    vecs[5] = '{5'd13, 8'hF0,  8'h3C,  4'd9,  8'hCC, 5'b00000, 1'b0, 3, 2};
    vecs[6] = '{5'd14, 8'd1,   8'd1,   4'd10, 8'h00, 5'b00000, 1'b1, 2, 0};
    vecs[7] = '{5'd11, 8'd3,   8'd9,   4'd15, 8'h00, 5'b00010, 1'b0, 3, 2};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_in1 = '0; cmd_in2 = '0;
    cmd_tag = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rsp_fields", {rsp_data, rsp_status, rsp_tag, rsp_error}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // SUB then CMPEQ on consecutive edges: responses at +3 and +6
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    cmd_op = 5'd2; cmd_in1 = 8'd5; cmd_in2 = 8'd7; cmd_tag = 4'd1;
    @(negedge clk);
    t = 1;
    cmd_op = 5'd11; cmd_in1 = 8'd9; cmd_in2 = 8'd9; cmd_tag = 4'd2;
    @(negedge clk);
    t = 2; cmd_valid = 1'b0;
    nresp = 0; t1 = 0; t2 = 0;
    d1 = '0; d2 = '0; s1 = '0; s2 = '0; g1 = '0; g2 = '0;
    while (t < 25 && nresp < 2) begin
      if (rsp_valid) begin
        if (nresp == 0) begin t1 = t; d1 = rsp_data; s1 = rsp_status; g1 = rsp_tag; end
        else begin t2 = t; d2 = rsp_data; s2 = rsp_status; g2 = rsp_tag; end
        nresp++;
      end
      @(negedge clk);
      t++;
    end
    chk("b2b_count", nresp, 2);
    chk("b2b_t1", t1, 3);
    chk("b2b_t2", t2, 6);
    chk("b2b_sub", {g1, d1, s1}, {4'd1, 8'hFE, 5'b01000});
    chk("b2b_cmpeq", {g2, d2, s2}, {4'd2, 8'h00, 5'b00100});
    repeat (2) @(negedge clk);

    // Backpressure: 1 held in RESP plus DEPTH queued, then ordered drain
    rsp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) begin
        cmd_valid = 1'b1; cmd_op = 5'd1;
        cmd_in1 = 8'(acc); cmd_in2 = 8'd1; cmd_tag = 4'(acc);
        acc++;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_fifo_count", fifo_count, 4);
    chk("bp_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
    rsp_ready = 1'b1; exp_tag = 0;
    for (int i = 0; i < 40 && exp_tag < 5; i++) begin
      if (rsp_valid) begin
        chk("bp_drain_tag", rsp_tag, exp_tag);
        chk("bp_drain_data", rsp_data, exp_tag + 1);
        exp_tag++;
      end
      @(negedge clk);
    end
    chk("bp_drain_count", exp_tag, 5);
    repeat (2) @(negedge clk);

    // Timeout with ALU never ready, then a normal command
    alu_gate = 1'b0;
    @(negedge clk);
    en0 = en_cnt;
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_in1 = 8'd50; cmd_in2 = 8'd60; cmd_tag = 4'd6;
    @(negedge clk);
    cmd_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("to_latency", lat, WAIT_MAX + 2);
    chk("to_rsp", {rsp_valid, rsp_error, rsp_data, rsp_status, rsp_tag},
        {1'b1, 1'b1, 8'h00, 5'b00000, 4'd6});
    @(negedge clk);
    chk("to_en_cycles", en_cnt - en0, WAIT_MAX + 1);
    alu_gate = 1'b1;
    run_vec(vecs[0]);

    // Reset while one command waits on the ALU and another is queued
    alu_gate = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 5'd1; cmd_in1 = 8'd1; cmd_in2 = 8'd1; cmd_tag = 4'd11;
    @(negedge clk);
    cmd_tag = 4'd12;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_enable", alu_enable, 1);
    chk("pre_rst_count", fifo_count, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_alu", {alu_enable, alu_op, alu_in1, alu_in2}, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_error, rsp_data, rsp_status, rsp_tag}, 0);
    chk("mid_rst_count", fifo_count, 0);
    @(negedge clk);
    reset_n = 1'b1; alu_gate = 1'b1; viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_enable || fifo_count != 0) viol++;
    end
    chk("post_rst_no_stale", viol, 0);
    run_vec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-issue stage directly upstream of the 8-bit ALU. Buffers operation requests from a producer in a small FIFO and drives the ALU's enable/operand/opcode inputs one command at a time. Captures the ALU's registered result and status once `alu_ready` is seen, then presents them with the command's tag on a valid/ready response port. Illegal opcodes and ALU no-response timeouts are reported as errors rather than issued or hung on.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, ≥2.
- `TAG_W`, 4: width of the command tag returned with each response.
- `WAIT_MAX`, 8: cycles to wait for `alu_ready` before a timeout error; ≥2.

Ports:
- `clk` in 1: single clock; everything samples on its rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; equals `!full`.
- `cmd_op` in 5: ALU opcode.
- `cmd_in1`, `cmd_in2` in 8: operands.
- `cmd_tag` in TAG_W: returned unchanged on the response.
- `alu_enable` out 1: ALU enable.
- `alu_in1`, `alu_in2` out 8: ALU operands.
- `alu_op` out 5: ALU opcode.
- `alu_out` in 8: ALU result.
- `alu_status` in 5: ALU status `{carry, neg, eq, lt, gt}`.
- `alu_ready` in 1: ALU result valid.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_data` out 8: captured result.
- `rsp_status` out 5: captured status.
- `rsp_tag` out TAG_W: tag of the completed command.
- `rsp_error` out 1: illegal opcode or timeout.
- `fifo_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO:
  - Push on `cmd_valid && cmd_ready`; entry is `{op, in1, in2, tag}`.
  - Pop occurs only at the capture/error edge (see FSM).
  - Push and pop on the same edge are both honoured; count is unchanged.
  - A push while full is impossible because `cmd_ready=0`.
  - Read and write pointers wrap modulo DEPTH.
- Legal opcodes are 5'd1–5'd13. Anything else is illegal.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - **IDLE**: `alu_enable=0`. Go to ISSUE when the FIFO is non-empty.
  - **ISSUE**:
    - Head opcode legal: drive `alu_enable=1` with `alu_op`/`alu_in1`/`alu_in2` from the FIFO head; go to WAIT; clear the wait counter.
    - Head opcode illegal: `alu_enable` stays 0; pop; load `rsp_data=0`, `rsp_status=0`, `rsp_error=1`, `rsp_tag=head tag`; go to RESP.
  - **WAIT**:
    - `alu_enable` stays 1 and operands are held stable.
    - If `alu_ready=1`: capture `alu_out`→`rsp_data`, `alu_status`→`rsp_status`, set `rsp_error=0`, pop, go to RESP.
    - Otherwise increment the counter. When it reaches WAIT_MAX: capture zeros, set `rsp_error=1`, pop, go to RESP.
  - **RESP**:
    - `alu_enable=0`, `rsp_valid=1`.
    - `rsp_*` are held stable until `rsp_valid && rsp_ready`.
    - On that handshake go to ISSUE if the FIFO is non-empty (including an entry pushed on the same edge), else IDLE.
- `alu_in1`, `alu_in2`, `alu_op` are driven to 0 whenever `alu_enable=0`.
- The ALU's own `alu_ready` while the sequencer is outside WAIT is ignored.

## Timing
- Reset values:
  - All outputs 0 except `cmd_ready=1`.
  - State is IDLE, FIFO empty, `fifo_count=0`.
  - Registered response fields are 0.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously.
  - In-flight and queued commands are discarded.
  - No response is produced for them.
- Latency, command accepted at edge E into an idle block:
  - ISSUE in cycle E+1.
  - WAIT in cycle E+2; the ALU raises `alu_ready` here.
  - Capture at the end of E+2.
  - `rsp_valid=1` from cycle E+3.
  - Minimum cmd→rsp latency is 3 cycles.
  - Throughput is one command per 3 cycles with `rsp_ready` held 1.
- Illegal opcode: `rsp_valid` in cycle E+2.
- Timeout: `rsp_valid` WAIT_MAX+1 cycles after ISSUE.
- Backpressure:
  - With `rsp_ready=0`, the block holds one command in RESP plus DEPTH in the FIFO.
  - `cmd_ready` falls combinationally when `fifo_count==DEPTH`.
- `fifo_count` updates on the push/pop edge.

## Test plan
- **ADD**: op=1, in1=200, in2=100, tag=3, `rsp_ready=1`. Required: `rsp_valid` 3 cycles after accept, `rsp_data=0x2C`, `rsp_status=5'b10000`, `rsp_tag=3`, `rsp_error=0`.
- **SUB then CMPEQ**, back-to-back:
  - SUB 5−7 → `rsp_data=0xFE`, `rsp_status=5'b01000`.
  - CMPEQ 9,9 → `rsp_data=0`, `rsp_status=5'b00100`.
  - Responses arrive in order and 3 cycles apart.
- **Backpressure**: `rsp_ready=0`, push commands continuously, DEPTH=4. Required: 5 accepted, then `cmd_ready=0` with `fifo_count=4`. Releasing `rsp_ready` drains all 5 in tag order.
- **Illegal opcode**: op=5'b11111, tag=7. Required: `alu_enable` never asserts, and the response is `rsp_error=1`, `rsp_data=0`, `rsp_tag=7`, 2 cycles after accept.
- **Timeout**: `alu_ready` tied 0, one ADD. Required: `alu_enable` high for WAIT_MAX+1 cycles, then a response with `rsp_error=1`; the next command issues normally.
- **Reset mid-WAIT**: `reset_n` low with 2 commands queued. Required: all outputs return to reset values, `fifo_count=0`, and no stale response appears after release.
